mr_wb_ram: RTL



---
 rtl/mr_wb_pkg.sv | 28 ++
 rtl/mr_wb_resp_pipe.sv | 56 +++++
 rtl/mr_wb_ram.sv | 114 +++++++++++
 3 files changed

// File: rtl/mr_wb_pkg.sv
// mr_wb_pkg: types and constants shared by the Wishbone RAM responder.
//   WB_SEL_W        byte-lane select width (one bit per byte of `XLEN)
//   WB_ADDR_W       word-address width, bits [`XLEN-1:`XLEN_GRAN] of a byte address
//   MAX_WB_LATENCY  largest supported ack/err latency
//   wb_resp_t       one response slot: {valid, err, data}
// `XLEN / `XLEN_GRAN normally come from config.svi; defaults are provided so
// this slice elaborates on its own.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

package mr_wb_pkg;

    localparam int WB_SEL_W       = `XLEN / 8;
    localparam int WB_ADDR_W      = `XLEN - `XLEN_GRAN;
    localparam int MAX_WB_LATENCY = 8;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [`XLEN-1:0]  data;
    } wb_resp_t;

endpackage

// File: rtl/mr_wb_resp_pipe.sv
// mr_wb_resp_pipe: fixed-latency response shift register for mr_wb_ram.
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of every slot (bus cycle dropped)
//   vld_p0          a beat was accepted at this edge
//   err_p0          the accepted beat is out of range
//   dat_p0          read data for the accepted beat (0 for writes/errors)
//   ack_o, err_o    response strobes, one cycle high per beat
//   dat_o           read data, nonzero only alongside a read ack
// A beat captured at edge N sits in the last slot after edge N+LATENCY-1, so
// the master samples it at edge N+LATENCY.

module mr_wb_resp_pipe
    import mr_wb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             vld_p0,
    input  logic             err_p0,
    input  logic [`XLEN-1:0] dat_p0,
    output logic             ack_o,
    output logic             err_o,
    output logic [`XLEN-1:0] dat_o
);

    wb_resp_t stage_p [LATENCY];
    wb_resp_t out_p;

    // Stage p0 -> p(LATENCY-1): every slot, data included, is cleared so that
    // dat_o reads 0 after reset or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_p[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_p[i] <= '0;
            end
        end else begin
            stage_p[0] <= '{valid: vld_p0, err: err_p0, data: dat_p0};
            for (int i = 1; i < LATENCY; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    // Output stage
    assign out_p = stage_p[LATENCY-1];
    assign ack_o = out_p.valid & ~out_p.err;
    assign err_o = out_p.valid & out_p.err;
    assign dat_o = out_p.data;

endmodule

// File: rtl/mr_wb_ram.sv
// mr_wb_ram: Wishbone B4 pipelined responder backed by a word-organised RAM.
//   clk, rst_n   clock, asynchronous active-low reset
//   cyc_i        bus cycle active; low flushes in-flight responses and stall
//   stb_i        request strobe (ignored without cyc_i)
//   we_i         1 = write, 0 = read
//   addr_i       word address
//   sel_i        byte-lane enables for writes (reads return the whole word)
//   dat_i        write data
//   stall_o      held high STALL_CYCLES cycles after every accepted beat
//   ack_o        beat completed, LATENCY edges after acceptance
//   err_o        beat addressed a word outside 0..DEPTH-1
//   dat_o        read data with a read ack, 0 otherwise
// RAM contents survive reset.

module mr_wb_ram
    import mr_wb_pkg::*;
#(
    parameter int    DEPTH        = 1024,
    parameter int    LATENCY      = 1,
    parameter int    STALL_CYCLES = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [WB_ADDR_W-1:0] addr_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic [`XLEN-1:0]     dat_i,
    output logic                 stall_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [`XLEN-1:0]     dat_o
);

    localparam int DATA_W = `XLEN;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**WB_ADDR_W still compares correctly.
    localparam logic [WB_ADDR_W:0] DEPTH_LIM  = (WB_ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]         STALL_LOAD = 4'(STALL_CYCLES);

    if (LATENCY < 1 || LATENCY > MAX_WB_LATENCY) begin : g_bad_latency
        $error("mr_wb_ram: LATENCY must be 1..%0d", MAX_WB_LATENCY);
    end
    if (STALL_CYCLES < 0 || STALL_CYCLES > 15) begin : g_bad_stall
        $error("mr_wb_ram: STALL_CYCLES must be 0..15");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        stall_cnt;
    logic              accept_p0;
    logic              in_range_p0;
    logic              wr_en_p0;
    logic [IDX_W-1:0]  word_idx_p0;
    logic [DATA_W-1:0] rd_word_p0;
    logic              resp_vld_p0;
    logic              resp_err_p0;
    logic [DATA_W-1:0] resp_dat_p0;

    // Stage p0: request decode at the accepting edge
    assign stall_o     = (stall_cnt != 4'd0);
    assign accept_p0   = cyc_i & stb_i & ~stall_o;
    // Full-width compare: a set upper address bit must not alias into the RAM.
    assign in_range_p0 = ({1'b0, addr_i} < DEPTH_LIM);
    assign word_idx_p0 = addr_i[IDX_W-1:0];
    assign wr_en_p0    = accept_p0 & we_i & in_range_p0;
    assign rd_word_p0  = mem[word_idx_p0];

    assign resp_vld_p0 = accept_p0;
    assign resp_err_p0 = accept_p0 & ~in_range_p0;
    assign resp_dat_p0 = (accept_p0 && !we_i && in_range_p0) ? rd_word_p0 : '0;

    always_ff @(posedge clk) begin
        if (wr_en_p0) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (sel_i[b]) begin
                    mem[word_idx_p0][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    // Dropping cyc_i abandons the transfer, so any pending stall is cancelled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 4'd0;
        end else if (!cyc_i) begin
            stall_cnt <= 4'd0;
        end else if (accept_p0) begin
            stall_cnt <= STALL_LOAD;
        end else if (stall_cnt != 4'd0) begin
            stall_cnt <= stall_cnt - 4'd1;
        end
    end

    // Stage p1..: fixed-latency response delivery
    mr_wb_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (~cyc_i),
        .vld_p0 (resp_vld_p0),
        .err_p0 (resp_err_p0),
        .dat_p0 (resp_dat_p0),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .dat_o  (dat_o)
    );

endmodule
